hilo_mult_controller: RTL and testbench
=======================================

# hilo_mult_controller

Multi-cycle sequencer for the CPU's combinational 32×32 multiplier and owner of the HI/LO architectural registers. It accepts MULT/MULTU/MTHI/MTLO operations from the EX stage and registers the operands. It holds them stable on the multiplier for a fixed number of cycles, so the multiplier path is a timed multicycle path. It then commits the 64-bit product to HI/LO, and stalls the pipeline while a multiply is in flight.

## Interface
Parameters:
- MUL_CYCLES, 4, cycles operands are held on the multiplier before the product is captured; legal range 1..16.

Ports:
- clock_signal  in  1  clock; every register updates on the rising edge.
- reset_signal_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation request from EX.
- op_code  in  2  00 = MULT (signed), 01 = MULTU, 10 = MTHI, 11 = MTLO.
- operand_a  in  32  multiplicand, or the MTHI/MTLO source value.
- operand_b  in  32  multiplier; ignored for MTHI/MTLO.
- flush  in  1  pipeline flush; aborts an in-flight multiply.
- busy  out  1  high while a multiply is in flight; the pipeline stalls issue and any MFHI/MFLO.
- done  out  1  one-cycle pulse after HI/LO are committed by a multiply.
- hi_out  out  32  current HI register value (the MFHI source).
- lo_out  out  32  current LO register value (the MFLO source).

## Operation
- States:
  - IDLE: ready for a new operation; busy is low.
  - RUN: a multiply is in flight; busy is high.
- Accept condition is op_valid && !busy && !flush.
- IDLE, accepted MULT/MULTU:
  - Latch operand_a and operand_b.
  - Latch the signed flag as op_code == 00.
  - Load cnt = MUL_CYCLES−1 and go to RUN.
- IDLE, accepted MTHI: HI ← operand_a at the same edge; stay in IDLE; done stays low.
- IDLE, accepted MTLO: LO ← operand_a at the same edge; stay in IDLE; done stays low.
- RUN, cnt ≠ 0: decrement cnt.
- RUN, cnt == 0:
  - HI ← product[63:32], LO ← product[31:0].
  - done = 1 in the next cycle.
  - Go to IDLE.
- RUN with flush = 1: go to IDLE at that edge; no HI/LO write and no done pulse. Flush outranks the cnt == 0 commit.
- op_valid while in RUN is ignored. The requester holds the request until busy drops.
- Multiplier drive:
  - enable = (state == RUN).
  - Active-high reset = ~reset_signal_n.
  - Signed select = the latched signed flag.
  - Operands = the latched registers.
- Arithmetic:
  - Product is the full 64 bits: two's-complement when signed, zero-extended when unsigned.
  - A zero operand yields 0.
  - No overflow or truncation.

## Timing
- Reset (asynchronous, immediate on assertion):
  - State = IDLE, cnt = 0.
  - Operand registers = 0, signed flag = 0.
  - HI = 0, LO = 0, so hi_out = lo_out = 0.
  - busy = 0, done = 0.
- Reset asserted mid-RUN discards the multiply. No commit follows deassertion.
- Multiply accepted at edge T0:
  - busy is high from after T0 through the cycle before edge T0+MUL_CYCLES.
  - HI/LO update at edge T0+MUL_CYCLES.
  - done is high for the cycle after T0+MUL_CYCLES.
- With MUL_CYCLES = 1, busy is high for exactly one cycle.
- busy is asserted only by state; it never combinationally depends on op_valid.
- Next accept: the earliest accept after a multiply is edge T0+MUL_CYCLES+1. busy is already low in that cycle, so back-to-back multiplies are spaced MUL_CYCLES+1 edges apart.
- MTHI/MTLO have 1-cycle latency: the new value is visible on hi_out/lo_out in the cycle after the accept edge.

## Structure
- Shared CPU package holds:
  - op_code constants OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO.
  - State encoding ST_IDLE, ST_RUN.
- One sub-module: instantiate the existing multiplier_unit as u_mul. The controller adds the registers, counter and FSM around it.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, MUL_CYCLES = 4:
  - busy is high for exactly 4 cycles.
  - HI = 0xFFFFFFFE, LO = 0x00000001.
  - done pulses once.
- MULT 0xFFFFFFFF (−1) × 0x00000002 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0x00000000.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles:
  - Each value is visible on the cycle after its accept edge.
  - busy and done stay low.
- MULT 3 × 5 with HI/LO preloaded to 0xAAAAAAAA, flush in the 2nd RUN cycle:
  - HI/LO stay 0xAAAAAAAA, no done pulse, busy drops next cycle.
  - A following MULT 3 × 5 gives LO = 15, HI = 0.
- reset_signal_n pulsed low mid-RUN after MULTU 7 × 9:
  - HI, LO, busy and done read 0 immediately.
  - Nothing is committed after reset releases.
  - op_valid held during the earlier busy phase had no effect.

Source files
------------

// File: rtl/hilo_mult_controller_pkg.sv
// Shared CPU definitions for the HI/LO multiply sequencer.
package hilo_mult_controller_pkg;

    // EX-stage op codes accepted by the HI/LO controller
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    // Counter is wide enough for MUL_CYCLES-1 with MUL_CYCLES up to 16
    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/multiplier_unit.sv
// Combinational 32x32 -> 64 multiplier. The controller holds its inputs
// stable for a fixed number of cycles, so this is a timed multicycle path.
module multiplier_unit (
    input  logic        enable,
    input  logic        rst,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product
);

    logic [63:0] a_ext;
    logic [63:0] b_ext;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the wide product
    // are then correct for both signed and unsigned operation.
    always_comb begin
        a_ext   = {{32{is_signed & a[31]}}, a};
        b_ext   = {{32{is_signed & b[31]}}, b};
        product = (enable && !rst) ? (a_ext * b_ext) : 64'd0;
    end

endmodule

// File: rtl/hilo_mult_controller.sv
// Multicycle multiply sequencer and owner of the HI/LO registers.
module hilo_mult_controller
    import hilo_mult_controller_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clock_signal,
    input  logic        reset_signal_n,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [31:0]        opa, opa_nxt;
    logic [31:0]        opb, opb_nxt;
    logic               sgn, sgn_nxt;
    logic [31:0]        hi, hi_nxt;
    logic [31:0]        lo, lo_nxt;
    logic               done_q, done_nxt;
    logic               accept;
    logic [63:0]        product;

    // Operands come only from the latched registers so they stay stable
    // for the whole RUN window regardless of what EX does meanwhile.
    multiplier_unit u_mul (
        .enable    (state == ST_RUN),
        .rst       (~reset_signal_n),
        .is_signed (sgn),
        .a         (opa),
        .b         (opb),
        .product   (product)
    );

    assign busy   = (state == ST_RUN);
    assign done   = done_q;
    assign hi_out = hi;
    assign lo_out = lo;
    assign accept = op_valid && !busy && !flush;

    // State, counter, operand and HI/LO registers
    always_ff @(posedge clock_signal or negedge reset_signal_n) begin
        if (!reset_signal_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            sgn    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            opa    <= opa_nxt;
            opb    <= opb_nxt;
            sgn    <= sgn_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state: accept in IDLE, count down in RUN, commit on cnt == 0
    // unless a flush arrives in the same cycle (flush wins).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        opa_nxt   = opa;
        opb_nxt   = opb;
        sgn_nxt   = sgn;
        hi_nxt    = hi;
        lo_nxt    = lo;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op_code)
                        OP_MULT, OP_MULTU: begin
                            opa_nxt   = operand_a;
                            opb_nxt   = operand_b;
                            sgn_nxt   = (op_code == OP_MULT);
                            cnt_nxt   = CNT_W'(MUL_CYCLES - 1);
                            state_nxt = ST_RUN;
                        end
                        OP_MTHI: hi_nxt = operand_a;
                        default: lo_nxt = operand_a;
                    endcase
                end
            end
            default: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == '0) begin
                    hi_nxt    = product[63:32];
                    lo_nxt    = product[31:0];
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_hilo_mult_controller.sv
// Self-checking bench for hilo_mult_controller with a plain-arithmetic model.
module tb_hilo_mult_controller;

    localparam int MC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi_out, lo_out;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    hilo_mult_controller #(.MUL_CYCLES(MC)) dut (
        .clock_signal   (clk),
        .reset_signal_n (rst_n),
        .op_valid       (op_valid),
        .op_code        (op_code),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .flush          (flush),
        .busy           (busy),
        .done           (done),
        .hi_out         (hi_out),
        .lo_out         (lo_out)
    );

    always #5 clk = ~clk;

    // Reference product from the architectural definition
    function automatic logic [63:0] ref_prod(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint s;
        if (op == 2'b00) begin
            s = longint'($signed(a)) * longint'($signed(b));
            return 64'(s);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Present one request for one accept edge, then drop it
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1; op_code = op; operand_a = a; operand_b = b;
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    // Observe n negedges after an accept: busy count, done count, first done index
    task automatic watch(input int n, output int nbusy, output int ndone, output int first_done);
        nbusy = 0; ndone = 0; first_done = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = k;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (hi_out !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi_out); end
        total++; if (lo_out !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_hi = '0; exp_lo = '0;
    endtask

    task automatic test_mul_directed(input string name, input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] whi,
                                     input logic [31:0] wlo);
        int nb, nd, fd;
        issue(op, a, b);
        watch(MC + 3, nb, nd, fd);
        total++; if (nb !== MC) begin bad++; $display("FAIL %s_busy_cycles got=%0d want=%0d", name, nb, MC); end
        total++; if (nd !== 1 || fd !== MC + 1) begin
            bad++; $display("FAIL %s_done got count=%0d at=%0d want count=1 at=%0d", name, nd, fd, MC + 1);
        end
        total++; if (hi_out !== whi) begin bad++; $display("FAIL %s_hi got=%h want=%h", name, hi_out, whi); end
        total++; if (lo_out !== wlo) begin bad++; $display("FAIL %s_lo got=%h want=%h", name, lo_out, wlo); end
        exp_hi = whi; exp_lo = wlo;
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        op_valid = 1'b1; op_code = 2'b10; operand_a = 32'h12345678; operand_b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 op_code = 2'b11; operand_a = 32'h9ABCDEF0;
        @(negedge clk);
        total++; if (hi_out !== 32'h12345678 || lo_out !== exp_lo) begin
            bad++; $display("FAIL mthi_visible got hi=%h lo=%h want hi=12345678 lo=%h", hi_out, lo_out, exp_lo);
        end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL mthi_flags got busy=%b done=%b want 0 0", busy, done);
        end
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        total++; if (lo_out !== 32'h9ABCDEF0 || hi_out !== 32'h12345678) begin
            bad++; $display("FAIL mtlo_visible got hi=%h lo=%h want 12345678 9abcdef0", hi_out, lo_out);
        end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL mtlo_flags got busy=%b done=%b want 0 0", busy, done);
        end
        exp_hi = 32'h12345678; exp_lo = 32'h9ABCDEF0;
    endtask

    task automatic test_flush();
        int nb, nd, fd;
        issue(2'b10, 32'hAAAAAAAA, 32'd0);
        issue(2'b11, 32'hAAAAAAAA, 32'd0);
        issue(2'b00, 32'd3, 32'd5);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
        watch(MC + 2, nb, nd, fd);
        total++; if (nd !== 0 || nb !== 0) begin
            bad++; $display("FAIL flush_no_done got done=%0d busy=%0d want 0 0", nd, nb);
        end
        total++; if (hi_out !== 32'hAAAAAAAA || lo_out !== 32'hAAAAAAAA) begin
            bad++; $display("FAIL flush_hilo got hi=%h lo=%h want aaaaaaaa", hi_out, lo_out);
        end
        test_mul_directed("after_flush", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        op_valid = 1'b1; op_code = 2'b01; operand_a = 32'd2; operand_b = 32'd3;
        @(posedge clk);
        #1 operand_a = 32'd4; operand_b = 32'd5;
        for (int k = 1; k <= MC; k++) begin
            @(negedge clk);
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy1 cycle=%0d got=%b want=1", k, busy); end
        end
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b1 || lo_out !== 32'd6) begin
            bad++; $display("FAIL b2b_gap got busy=%b done=%b lo=%h want 0 1 6", busy, done, lo_out);
        end
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept got busy=%b want=1", busy); end
        repeat (MC) @(negedge clk);
        total++; if (done !== 1'b1 || lo_out !== 32'd20 || hi_out !== 32'd0) begin
            bad++; $display("FAIL b2b_second got done=%b hi=%h lo=%h want 1 0 20", done, hi_out, lo_out);
        end
        exp_hi = 32'd0; exp_lo = 32'd20;
    endtask

    task automatic test_reset_mid_run();
        int nb, nd, fd;
        @(negedge clk);
        op_valid = 1'b1; op_code = 2'b01; operand_a = 32'd7; operand_b = 32'd9;
        @(posedge clk);
        // keep requesting (now an MTHI) while busy; it must be ignored
        #1 op_code = 2'b10; operand_a = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b1 || hi_out !== exp_hi) begin
            bad++; $display("FAIL ignored_in_run got busy=%b hi=%h want 1 %h", busy, hi_out, exp_hi);
        end
        op_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        total++; if (hi_out !== 32'd0 || lo_out !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL async_reset got hi=%h lo=%h busy=%b done=%b want all 0", hi_out, lo_out, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_hi = '0; exp_lo = '0;
        watch(MC + 3, nb, nd, fd);
        total++; if (nd !== 0 || nb !== 0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            bad++; $display("FAIL post_reset got done=%0d busy=%0d hi=%h lo=%h want 0 0 0 0", nd, nb, hi_out, lo_out);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random(input int n);
        int nb, nd, fd, k;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] p;
        for (int i = 0; i < n; i++) begin
            op = 2'($urandom_range(0, 3));
            a = pick(); b = pick();
            if (op == 2'b10) begin
                issue(op, a, b);
                @(negedge clk);
                exp_hi = a;
                total++; if (hi_out !== exp_hi || lo_out !== exp_lo || busy !== 1'b0) begin
                    bad++; $display("FAIL rnd%0d_mthi got hi=%h lo=%h busy=%b want %h %h 0", i, hi_out, lo_out, busy, exp_hi, exp_lo);
                end
            end else if (op == 2'b11) begin
                issue(op, a, b);
                @(negedge clk);
                exp_lo = a;
                total++; if (hi_out !== exp_hi || lo_out !== exp_lo || busy !== 1'b0) begin
                    bad++; $display("FAIL rnd%0d_mtlo got hi=%h lo=%h busy=%b want %h %h 0", i, hi_out, lo_out, busy, exp_hi, exp_lo);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                // flushed multiply, including flush on the final cycle
                k = $urandom_range(1, MC);
                issue(op, a, b);
                repeat (k - 1) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
                watch(MC + 1, nb, nd, fd);
                total++; if (nd !== 0 || nb !== 0 || hi_out !== exp_hi || lo_out !== exp_lo) begin
                    bad++; $display("FAIL rnd%0d_flush k=%0d got done=%0d busy=%0d hi=%h lo=%h want 0 0 %h %h",
                                    i, k, nd, nb, hi_out, lo_out, exp_hi, exp_lo);
                end
            end else begin
                p = ref_prod(op, a, b);
                issue(op, a, b);
                watch(MC + 2, nb, nd, fd);
                exp_hi = p[63:32]; exp_lo = p[31:0];
                total++; if (nb !== MC || nd !== 1 || fd !== MC + 1 || hi_out !== exp_hi || lo_out !== exp_lo) begin
                    bad++; $display("FAIL rnd%0d_mul op=%0d a=%h b=%h got busy=%0d done=%0d@%0d hi=%h lo=%h want %0d 1@%0d %h %h",
                                    i, op, a, b, nb, nd, fd, hi_out, lo_out, MC, MC + 1, exp_hi, exp_lo);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_directed("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        test_mul_directed("mult_neg1x2", 2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
        test_mul_directed("mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        test_mul_directed("mult_zero", 2'b00, 32'h00000000, 32'h80000001, 32'h00000000, 32'h00000000);
        test_mthi_mtlo();
        test_flush();
        test_back_to_back();
        test_reset_mid_run();
        test_random(60);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
